// File: rtl/multiplexer_scan.sv
// Registered N-channel x W-bit multiplexer with manual select and round-robin
// auto-scan, where each channel is held for DWELL enabled cycles.
module multiplexer_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] X,
  input  logic [SELW-1:0]           C,
  input  logic                      scan,
  input  logic                      en,
  output logic [WIDTH-1:0]          Y,
  output logic [SELW-1:0]           CH,
  output logic                      wrap
);

  localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   NCH      = (SELW + 1)'(CHANNELS);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [SELW-1:0]   ch_nx, ch_man;
  logic              wrap_nx;
  logic [WIDTH-1:0]  chan [2**SELW];

  // Pad the channel table to the full select range so any index is defined.
  for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
    if (k < CHANNELS) begin : g_in
      assign chan[k] = X[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  // Out-of-range select keeps the previous channel.
  assign ch_man = ({1'b0, C} < NCH) ? C : CH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= MANUAL;
    else if (en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MANUAL:  if (scan)  state_nx = SCAN;
      SCAN:    if (!scan) state_nx = MANUAL;
      default: state_nx = MANUAL;
    endcase
  end

  always_comb begin
    ch_nx   = ch_man;
    cnt_nx  = '0;
    wrap_nx = 1'b0;
    if (scan) begin
      if (state == MANUAL) begin
        ch_nx = CH;
      end else if (cnt == CNT_LAST) begin
        ch_nx   = (CH == CH_LAST) ? '0 : CH + 1'b1;
        wrap_nx = (CH == CH_LAST);
      end else begin
        ch_nx  = CH;
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CH   <= '0;
      Y    <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en & wrap_nx;
      if (en) begin
        CH  <= ch_nx;
        Y   <= chan[ch_nx];
        cnt <= cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_scan.sv
// Bench for multiplexer_scan: two configurations (4ch x 1b, 3ch x 2b) checked
// each cycle against a sweep-position model, plus directed literal checks.
module tb_multiplexer_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] x4 = '0;
  logic [5:0] x3 = '0;
  logic [1:0] C = '0;
  logic       scan = 1'b0;
  logic       en = 1'b1;
  logic       Y4;
  logic [1:0] Y3;
  logic [1:0] CH4, CH3;
  logic       wrap4, wrap3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multiplexer_scan #(.WIDTH(1), .CHANNELS(4), .SELW(2), .DWELL(4)) dut4 (
    .clk(clk), .reset(reset), .X(x4), .C(C), .scan(scan), .en(en),
    .Y(Y4), .CH(CH4), .wrap(wrap4));

  multiplexer_scan #(.WIDTH(2), .CHANNELS(3), .SELW(2), .DWELL(3)) dut3 (
    .clk(clk), .reset(reset), .X(x3), .C(C), .scan(scan), .en(en),
    .Y(Y3), .CH(CH3), .wrap(wrap3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: position within the full sweep, pos = ch*DWELL + dwell step.
  // Manual mode keeps pos at the start of the selected channel.
  function automatic void step(input int nch, input int dw, input bit s, input bit e,
                               input int c, input bit cur_s, input int cur_p,
                               output bit n_s, output int n_p, output bit n_w);
    n_s = cur_s; n_p = cur_p; n_w = 1'b0;
    if (!e) return;
    if (!s) begin
      n_s = 1'b0;
      n_p = (c < nch) ? c * dw : (cur_p / dw) * dw;
    end else if (!cur_s) begin
      n_s = 1'b1;
      n_p = (cur_p / dw) * dw;
    end else begin
      n_p = (cur_p + 1) % (nch * dw);
      n_w = (n_p == 0);
    end
  endfunction

  bit         m4_s, m3_s, m4_w, m3_w;
  int         m4_p, m3_p;
  logic       m4_y;
  logic [1:0] m3_y;

  always @(posedge clk or posedge reset) begin : mdl
    bit ns; int np; bit nw;
    if (reset) begin
      m4_s <= 0; m4_p <= 0; m4_w <= 0; m4_y <= '0;
      m3_s <= 0; m3_p <= 0; m3_w <= 0; m3_y <= '0;
    end else begin
      step(4, 4, scan, en, int'(C), m4_s, m4_p, ns, np, nw);
      m4_s <= ns; m4_p <= np; m4_w <= nw;
      if (en) m4_y <= x4[np / 4];
      step(3, 3, scan, en, int'(C), m3_s, m3_p, ns, np, nw);
      m3_s <= ns; m3_p <= np; m3_w <= nw;
      if (en) m3_y <= x3[(np / 3) * 2 +: 2];
    end
  end

  always @(negedge clk) begin
    chk("model_y4", 32'(Y4), 32'(m4_y));
    chk("model_ch4", 32'(CH4), 32'(m4_p / 4));
    chk("model_wrap4", 32'(wrap4), 32'(m4_w));
    chk("model_y3", 32'(Y3), 32'(m3_y));
    chk("model_ch3", 32'(CH3), 32'(m3_p / 3));
    chk("model_wrap3", 32'(wrap3), 32'(m3_w));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int seq[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    logic [3:0] xv;
    #1 reset = 1'b1;
    #2;
    chk("rst_y", 32'(Y4), 0);
    chk("rst_ch", 32'(CH4), 0);
    chk("rst_wrap", 32'(wrap4), 0);
    tick();
    reset = 1'b0;

    // manual sweep of every data/select combination
    for (int x = 0; x < 16; x++) begin
      for (int c = 0; c < 4; c++) begin
        xv = 4'(x);
        x4 = xv; C = 2'(c);
        tick();
        chk("man_y", 32'(Y4), 32'(xv[c]));
        chk("man_ch", 32'(CH4), 32'(c));
      end
    end

    // full scan sweep from channel 0
    x4 = 4'b1010; C = 2'd0; tick();
    scan = 1'b1;
    xv = 4'b1010;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("scan_ch", 32'(CH4), 32'(seq[i]));
      chk("scan_y", 32'(Y4), 32'(xv[seq[i]]));
      chk("scan_wrap", 32'(wrap4), (i == 16) ? 1 : 0);
    end

    // freeze at CH=2 with one dwell cycle already spent
    repeat (9) tick();
    chk("frz_pre_ch", 32'(CH4), 2);
    en = 1'b0; x4 = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_ch", 32'(CH4), 2);
      chk("frz_y", 32'(Y4), 0);
      chk("frz_wrap", 32'(wrap4), 0);
    end
    en = 1'b1; x4 = 4'b1010;
    tick(); chk("resume_ch0", 32'(CH4), 2);
    tick(); chk("resume_ch1", 32'(CH4), 2);
    tick(); chk("resume_ch2", 32'(CH4), 3);
    chk("resume_y", 32'(Y4), 1);

    // out-of-range select on the 3-channel instance holds channel 1
    scan = 1'b0; C = 2'd1; x3 = 6'($urandom);
    tick();
    chk("oor_ch_a", 32'(CH3), 1);
    chk("oor_y_a", 32'(Y3), 32'(x3[3:2]));
    C = 2'd3;
    for (int i = 0; i < 4; i++) begin
      x3 = 6'($urandom);
      tick();
      chk("oor_ch", 32'(CH3), 1);
      chk("oor_y", 32'(Y3), 32'(x3[3:2]));
    end

    // leave scan at CH=3, then re-enter from the manually chosen channel
    scan = 1'b1; tick(); tick();
    chk("exit_pre_ch", 32'(CH4), 3);
    scan = 1'b0; C = 2'd1; tick();
    chk("exit_ch", 32'(CH4), 1);
    chk("exit_wrap", 32'(wrap4), 0);
    scan = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reent_ch", 32'(CH4), (i < 4) ? 1 : 2);
    end

    // asynchronous reset between edges
    x4 = 4'hf; x3 = 6'h3f;
    repeat (6) tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_y4", 32'(Y4), 0);
    chk("arst_ch4", 32'(CH4), 0);
    chk("arst_wrap4", 32'(wrap4), 0);
    chk("arst_y3", 32'(Y3), 0);
    chk("arst_ch3", 32'(CH3), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_ch", 32'(CH4), (i < 4) ? 0 : 1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      x4 = 4'($urandom);
      x3 = 6'($urandom);
      C = 2'($urandom);
      if ($urandom_range(15) == 0) scan = ~scan;
      en = ($urandom_range(7) != 0);
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
